// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of core stores drained to data memory, with load forwarding.
// Optional build macro STORE_BUFFER_COALESCE_EN merges a store into the newest entry on a word match.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [AW-1:0] dataaddr,
  input  logic [DW-1:0] writedata,
  output logic          stall,
  output logic          rd_hit,
  output logic [DW-1:0] rd_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          full, pop, push, coalesce;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign mem_we    = !empty;
  assign mem_addr  = addr_q[head_q];
  assign mem_wdata = data_q[head_q];
  assign pop       = mem_we && mem_ready;

`ifdef STORE_BUFFER_COALESCE_EN
  logic [PW-1:0] newest;
  assign newest = tail_q - PW'(1);
  // A newest entry that is also the departing head cannot absorb the store.
  assign coalesce = memwrite && !empty
                 && (addr_q[newest][AW-1:2] == dataaddr[AW-1:2])
                 && !((newest == head_q) && pop);
`else
  assign coalesce = 1'b0;
`endif

  assign stall = full && memwrite && !coalesce;
  assign push  = memwrite && !stall && !coalesce;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payloads carry no reset; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= dataaddr;
      data_q[tail_q] <= writedata;
    end
`ifdef STORE_BUFFER_COALESCE_EN
    else if (coalesce) begin
      addr_q[newest] <= dataaddr;
      data_q[newest] <= writedata;
    end
`endif
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx][AW-1:2] == dataaddr[AW-1:2])) begin
        rd_hit  = 1'b1;
        rd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic        stall;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        empty;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataaddr(dataaddr),
    .writedata(writedata), .stall(stall), .rd_hit(rd_hit), .rd_data(rd_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check settled outputs, then advance the model.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    logic        coal, exp_stall, hit;
    logic [31:0] fd;
    int          n;
    memwrite = mw; dataaddr = a; writedata = d; mem_ready = rdy;
    #1;
    n = q.size();
    coal = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
    if (mw && n > 0 && q[n-1].a[31:2] == a[31:2] && !(n == 1 && rdy)) coal = 1'b1;
`endif
    exp_stall = (n == DEPTH) && mw && !coal;
    hit = 1'b0; fd = 32'd0;
    foreach (q[i]) if (q[i].a[31:2] == a[31:2]) begin hit = 1'b1; fd = q[i].d; end
    chk("stall", 64'(stall), 64'(exp_stall));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("mem_we", 64'(mem_we), 64'(n != 0));
    chk("rd_hit", 64'(rd_hit), 64'(hit));
    chk("rd_data", 64'(rd_data), 64'(fd));
    if (n != 0) begin
      chk("mem_addr", 64'(mem_addr), 64'(q[0].a));
      chk("mem_wdata", 64'(mem_wdata), 64'(q[0].d));
    end
    @(posedge clk);
    if (coal) q[n-1] = '{a: a, d: d};
    if (n != 0 && rdy) void'(q.pop_front());
    if (mw && !exp_stall && !coal) q.push_back('{a: a, d: d});
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 8; k++) step(1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataaddr = '0; writedata = '0; mem_ready = 1'b0;
    #22;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_rd_hit", 64'(rd_hit), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single store held until memory accepts it.
    step(1'b1, 32'd84, 32'd7, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0);

    // Fill, stall on the fifth store, then drain in order.
    step(1'b1, 32'd0, 32'd1, 1'b0);
    step(1'b1, 32'd4, 32'd2, 1'b0);
    step(1'b1, 32'd8, 32'd3, 1'b0);
    step(1'b1, 32'd12, 32'd4, 1'b0);
    step(1'b1, 32'd16, 32'd5, 1'b0);
    step(1'b1, 32'd16, 32'd5, 1'b1);
    step(1'b1, 32'd16, 32'd5, 1'b0);
    drain();

    // Youngest match wins; byte offset ignored; miss gives zero.
    step(1'b1, 32'd84, 32'd7, 1'b0);
    step(1'b1, 32'd84, 32'd9, 1'b0);
    step(1'b0, 32'd86, 32'd0, 1'b0);
    step(1'b0, 32'd88, 32'd0, 1'b0);
    drain();

    // Streaming with memory always ready: wraps the pointers several times.
    for (int k = 0; k < 10; k++) step(1'b1, 32'(k * 4 + 200), 32'(k + 100), 1'b1);
    drain();

    // Asynchronous reset in the middle of a drain.
    step(1'b1, 32'd20, 32'd11, 1'b0);
    step(1'b1, 32'd24, 32'd12, 1'b0);
    step(1'b1, 32'd28, 32'd13, 1'b0);
    memwrite = 1'b0; mem_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_mem_we", 64'(mem_we), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 32'd84, 32'd7, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1);

    // Full buffer, store to the newest entry's word.
    step(1'b1, 32'd100, 32'd21, 1'b0);
    step(1'b1, 32'd104, 32'd22, 1'b0);
    step(1'b1, 32'd108, 32'd23, 1'b0);
    step(1'b1, 32'd112, 32'd24, 1'b0);
    step(1'b1, 32'd114, 32'hAA, 1'b0);
    step(1'b0, 32'd112, 32'd0, 1'b0);
    drain();

    // Random traffic over a small address window to provoke matches and wraps.
    for (int k = 0; k < 400; k++)
      step(1'($urandom % 2), 32'(($urandom % 8) * 4 + ($urandom % 4)), $urandom, 1'($urandom % 2));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
